// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder with valid/ready request/response handshakes and a program-load port.
// Define IMEM_RANDOM_LATENCY_EN to replace the fixed LATENCY with an LFSR-driven 1..4 cycle latency.
module imem_fetch_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] ERR_INST   = 32'h0010_0073
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_inst,
  output logic                  resp_err,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_mem [2**DEPTH_LOG2];
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  w_lat_m1;
  logic [31:0] r_word;
  logic        r_fault;
  logic [31:0] r_inst;
  logic        r_err;
  logic [31:0] w_offset;
  logic [31:0] w_idx;
  logic [31:0] w_rd_word;
  logic        w_fault;
  logic        w_req_ready;
  logic        w_accept;
  logic        w_out_load;
  logic [31:0] w_out_inst;
  logic        w_out_err;

  // Address decode; addresses below BASE_ADDR fault instead of wrapping into the array.
  assign w_offset  = req_addr - BASE_ADDR;
  assign w_idx     = w_offset >> 2;
  assign w_fault   = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                     ((w_idx >> DEPTH_LOG2) != '0);
  assign w_rd_word = r_mem[w_idx[DEPTH_LOG2-1:0]];

`ifdef IMEM_RANDOM_LATENCY_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_lat_m1 = {2'b00, r_lfsr[1:0]};
`else
  assign w_lat_m1 = 4'(LATENCY - 1);
`endif

  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // Response registers load only on entry to RESP so they hold their last value while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_ready = 1'b0;
    w_accept    = 1'b0;
    w_out_load  = 1'b0;
    w_out_inst  = r_fault ? ERR_INST : r_word;
    w_out_err   = r_fault;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !ld_en;
        w_accept    = req_valid && !ld_en;
        if (w_accept) begin
          w_cnt_nxt = w_lat_m1;
          if (w_lat_m1 == 4'd0) begin
            w_state_nxt = S_RESP;
            w_out_load  = 1'b1;
            w_out_inst  = w_fault ? ERR_INST : w_rd_word;
            w_out_err   = w_fault;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RESP;
          w_out_load  = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
      r_fault <= 1'b0;
      r_inst  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_word  <= w_rd_word;
        r_fault <= w_fault;
      end
      if (w_out_load) begin
        r_inst <= w_out_inst;
        r_err  <= w_out_err;
      end
    end
  end

  assign req_ready  = w_req_ready && !rst;
  assign resp_valid = (r_state == S_RESP);
  assign resp_inst  = r_inst;
  assign resp_err   = r_err;

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder serving the core's fetch side: accepts a PC-addressed fetch request and returns the 32-bit instruction word.
- Backed by an internal word array that is loaded through a dedicated program-load write port.
- Adds request/response valid/ready handshakes with configurable response latency, so the core can later move off the ideal combinational instruction input.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address of word 0; equals the core reset PC.
- LATENCY, 1, cycles from the accepting edge to resp_valid high; legal range 1..15.
- ERR_INST, 32'h0010_0073, word returned on a faulting fetch (ebreak, so simulation halts).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address (PC).
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_inst  out  32  fetched instruction.
- resp_err  out  1  fetch fault: misaligned or out of range.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  DEPTH_LOG2  word index to write.
- ld_data  in  32  word to write.

Behaviour:
- Reset values: req_ready=0 during reset, 1 in the first cycle after reset; resp_valid=0; resp_inst=0; resp_err=0; latency counter=0; state=IDLE.
- The array is not cleared by reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE: req_ready = !ld_en.
- Accept occurs when req_valid && req_ready at a rising edge. On accept:
  - Word index is (req_addr - BASE_ADDR) >> 2.
  - The array word is sampled and held internally.
  - Fault is set if req_addr[1:0] != 0, or req_addr < BASE_ADDR, or the index >= 2**DEPTH_LOG2.
  - Counter is loaded with LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- WAIT: req_ready=0; counter decrements each cycle; when the counter is 1, go to RESP next cycle.
  - Net effect: resp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1.
  - resp_inst = sampled word, or ERR_INST if fault.
  - resp_err = fault.
  - resp_inst and resp_err stay stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE. resp_valid drops and resp_inst and resp_err keep their last values.
- Throughput: at most one outstanding request. There is no accept in RESP or WAIT, so one bubble cycle occurs between handshakes (IDLE always lasts at least one cycle).
- Load port:
  - Write to array[ld_addr] at the edge when ld_en=1, allowed in any state.
  - It does not alter an in-flight response, since data is already sampled.
  - ld_en and accept never coincide, because req_ready is deasserted when ld_en=1.
- Address arithmetic is modulo 2**32. Addresses below BASE_ADDR fault rather than wrap into the array.
- Reset mid-operation (WAIT or RESP): the next state is IDLE, resp_valid=0, and the pending response is discarded.
- req_valid while busy is ignored. The requester must hold req_valid and req_addr until accepted.
- resp_ready while resp_valid=0 has no effect.

Optional Feature:
- Macro: IMEM_RANDOM_LATENCY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded to 8'hA5 on reset and advances every cycle.
  - On accept, the effective latency is 1 + lfsr[1:0], i.e. 1..4, and the LATENCY parameter is ignored.
  - All other behaviour is unchanged; this stresses core stall handling.
- Undefined: the LFSR is absent and the latency is the fixed LATENCY.

Test Plan:
- Load and basic fetch: load words 0..3 with 0x00000013, 0x00100093, 0x00200113, 0x00100073; request 0x80000000, then 0x80000004, with resp_ready=1 and LATENCY=1 → resp_valid one cycle after each accept; resp_inst=0x00000013, then 0x00100093; resp_err=0.
- Latency: LATENCY=3, request 0x80000008 → resp_valid high exactly 3 cycles after the accepting edge; resp_inst=0x00200113; req_ready=0 throughout WAIT and RESP.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid, resp_inst and resp_err stable all 5 cycles; with resp_ready=1, the handshake completes and req_ready=1 the next cycle.
- Faults: request 0x80000002, then 0x7FFFFFFC, then BASE + 4·2**DEPTH_LOG2 → each response has resp_err=1 and resp_inst=0x00100073.
- Load/fetch interaction:
  - ld_en=1 with req_valid=1 → req_ready=0 and no accept that cycle.
  - Writing the in-flight word during WAIT → the old sampled value is returned.
  - rst asserted during WAIT → resp_valid=0 and state IDLE next cycle; the array contents are retained.
- With IMEM_RANDOM_LATENCY_EN: 20 sequential fetches → every latency in 1..4 and matching the LFSR sequence from seed 0xA5; data is correct for every fetch.
